jpeg_entropy_bit_packer: RTL and testbench
==========================================

// Module: jpeg_entropy_bit_packer
// PURPOSE
//  Sits directly downstream of the JPEG Huffman/parity code-generation cones.
//  Accepts variable-length codewords of 0..16 bits, packs them MSB-first into a
//  bit accumulator, and emits bytes on a valid/ready stream. Inserts 0x00 after
//  every emitted 0xFF byte, as JPEG byte stuffing requires.
//  On request, flushes the stream: pads the tail with 1s to a byte boundary.
// PARAMETERS
//  CODE_W   16  max codeword width; in_code is right-aligned in CODE_W bits
//  LEN_W    5   width of in_len; legal lengths are 0..CODE_W
//  ACC_BITS 32  accumulator capacity in bits; must be >= CODE_W+8
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       synchronous active-low reset
//  in_valid   in   1       codeword present
//  in_ready   out  1       packer can accept the codeword this cycle
//  in_code    in   CODE_W  codeword; low in_len bits are valid, sent MSB first
//  in_len     in   LEN_W   codeword length; 0 = no-op; >CODE_W is treated as CODE_W
//  flush      in   1       1-cycle pulse: drain, pad and close the segment
//  out_valid  out  1       out_byte is valid
//  out_ready  in   1       consumer takes out_byte when out_valid&&out_ready
//  out_byte   out  8       packed byte, first bit = bit 7
//  flush_done out  1       1-cycle pulse once the flush is complete
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): fill=0, state=RUN, in_ready=0, out_valid=0,
//    out_byte=8'h00, flush_done=0. in_ready is 1 in the first cycle after reset.
//  - States: RUN, STUFF, FLUSH, DONE.
//  - Accept: in_valid&&in_ready. in_ready = (state==RUN||state==STUFF) &&
//    fill+CODE_W<=ACC_BITS. Capacity uses the current fill; a drain in the same
//    cycle is not credited. Bits above in_len are masked to 0.
//  - Emit: out_valid=1 when fill>=8 in RUN/FLUSH, or state==STUFF.
//    out_byte is the top 8 buffered bits and is registered. Bits accepted in
//    cycle N are visible on out_byte no earlier than cycle N+1.
//  - Simultaneous accept and emit: next fill = fill - 8 + len.
//    Buffered bit order is preserved.
//  - out_byte and out_valid hold stable while out_valid && !out_ready.
//  - RUN->STUFF: a byte equal to 8'hFF is handshaken. In STUFF, out_byte=8'h00
//    and out_valid=1, with no buffer bits consumed. Its handshake returns to the
//    previous state (RUN or FLUSH).
//  - RUN->FLUSH: flush=1. An input accepted in that same cycle is included in
//    the flush. flush while not in RUN is ignored. in_ready=0 in FLUSH and DONE.
//  - FLUSH: drain whole bytes. If 0<fill<8, pad the low bits with 1s to 8 bits
//    and emit. A pad result of 8'hFF is stuffed like any other 0xFF.
//  - FLUSH->DONE: fill==0 and no stuff pending. DONE pulses flush_done for one
//    cycle, then returns to RUN.
//  - A flush with fill==0 completes with no bytes emitted.
//  - Reset mid-operation: buffered bits and any pending stuff byte are discarded.
// CONFIGURATION
//  JPEG_PACK_PARITY_EN defined: adds output port out_par (1 bit) = ~^out_byte.
//    This is the odd-parity XNOR of the byte, registered alongside out_byte;
//    reset value 1.
//  JPEG_PACK_PARITY_EN undefined: port absent; all other behaviour identical.
// TESTING
//  1. out_ready=1: (code 3'b101,len 3), then (5'b11110,len 5)
//     -> single byte 8'hBE, fill=0.
//  2. (8'hFF,len 8) -> out_byte 8'hFF, then 8'h00 on the next handshake,
//     then out_valid=0.
//  3. (3'b010,len 3) then flush -> byte 8'h5F; flush_done pulses one cycle after
//     its handshake.
//  4. out_ready=0: two 16-bit codes accepted, in_ready=0 on the third.
//     Release out_ready -> 4 bytes in input order, then in_ready=1.
//  5. Accept 20 bits, pull rst_n=0 for one cycle -> out_valid=0, in_ready=0,
//     then a clean restart with no stale bytes.
//  6. With JPEG_PACK_PARITY_EN: bytes 8'h00 / 8'h01 / 8'hBE -> out_par=1/0/1.

Source files
------------

// File: rtl/jpeg_entropy_bit_packer.sv
// rtl/jpeg_entropy_bit_packer.sv - MSB-first codeword packer with 0xFF stuffing and 1s-padded flush (optional JPEG_PACK_PARITY_EN adds out_par)
module jpeg_entropy_bit_packer #(
    parameter int CODE_W   = 16,
    parameter int LEN_W    = 5,
    parameter int ACC_BITS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
`ifdef JPEG_PACK_PARITY_EN
    output logic              flush_done,
    output logic              out_par
`else
    output logic              flush_done
`endif
);

    localparam int FW = $clog2(ACC_BITS + 1);

    typedef enum logic [1:0] {RUN, STUFF, FLUSH, DONE} state_t;

    // Buffered bits live MSB-aligned in acc; everything below the top fill bits is kept zero.
    state_t              state, state_n, ret, ret_n;
    logic [ACC_BITS-1:0] acc, acc_d, acc_n, code_w;
    logic [FW-1:0]       fill, fill_d, fill_n;
    logic [LEN_W-1:0]    len_e, sh;
    logic [CODE_W-1:0]   mask;
    logic                hs, take, out_valid_n, in_ready_n;
    logic [7:0]          out_byte_n;

    assign hs   = out_valid && out_ready;
    assign take = in_valid && in_ready;

    // Clamp the length, mask stray high bits and left-align the codeword in accumulator width.
    always_comb begin
        mask  = '0;
        len_e = (in_len > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : in_len;
        for (int i = 0; i < CODE_W; i++) begin
            mask[i] = (i < int'(len_e));
        end
        sh     = LEN_W'(CODE_W) - len_e;
        code_w = {in_code & mask, {(ACC_BITS-CODE_W){1'b0}}} << sh;
    end

    // Next-state: drain on handshake, decide stuffing/flush transitions, then append any accepted code.
    always_comb begin
        acc_d   = acc;
        fill_d  = fill;
        state_n = state;
        ret_n   = ret;
        case (state)
            RUN: begin
                if (hs) begin
                    acc_d  = acc << 8;
                    fill_d = fill - FW'(8);
                end
                if (hs && out_byte == 8'hFF) begin
                    state_n = STUFF;
                    ret_n   = flush ? FLUSH : RUN;
                end else if (flush) begin
                    state_n = FLUSH;
                end
            end
            STUFF: begin
                if (hs) state_n = ret;
            end
            FLUSH: begin
                if (hs) begin
                    acc_d  = acc << 8;
                    fill_d = (fill >= FW'(8)) ? fill - FW'(8) : '0;
                    if (out_byte == 8'hFF) begin
                        state_n = STUFF;
                        ret_n   = FLUSH;
                    end
                end else if (fill == '0) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = RUN;
            default: state_n = RUN;
        endcase
        acc_n  = acc_d;
        fill_n = fill_d;
        if (take) begin
            acc_n  = acc_d | (code_w >> fill_d);
            fill_n = fill_d + FW'(len_e);
        end
        in_ready_n  = (state_n == RUN || state_n == STUFF) &&
                      (({1'b0, fill_n} + (FW+1)'(CODE_W)) <= (FW+1)'(ACC_BITS));
        out_valid_n = (state_n == STUFF) ||
                      (state_n == RUN   && fill_n >= FW'(8)) ||
                      (state_n == FLUSH && fill_n != '0);
        if (state_n == STUFF)
            out_byte_n = 8'h00;
        else if (state_n == FLUSH && fill_n < FW'(8))
            out_byte_n = acc_n[ACC_BITS-1 -: 8] | (8'hFF >> fill_n);
        else
            out_byte_n = acc_n[ACC_BITS-1 -: 8];
    end

    // State and registered outputs; reset discards buffered bits and any pending stuff byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            ret        <= RUN;
            acc        <= '0;
            fill       <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_byte   <= 8'h00;
            flush_done <= 1'b0;
`ifdef JPEG_PACK_PARITY_EN
            out_par    <= 1'b1;
`endif
        end else begin
            state      <= state_n;
            ret        <= ret_n;
            acc        <= acc_n;
            fill       <= fill_n;
            in_ready   <= in_ready_n;
            out_valid  <= out_valid_n;
            out_byte   <= out_byte_n;
            flush_done <= (state_n == DONE);
`ifdef JPEG_PACK_PARITY_EN
            out_par    <= ~^out_byte_n;
`endif
        end
    end

endmodule

// File: tb/tb_jpeg_entropy_bit_packer.sv
// tb/tb_jpeg_entropy_bit_packer.sv - directed and randomized checks of jpeg_entropy_bit_packer against a bit-queue model
module tb_jpeg_entropy_bit_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_code = '0;
    logic [4:0]  in_len = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_byte;
    logic        flush_done;
`ifdef JPEG_PACK_PARITY_EN
    logic        out_par;
`endif

    int errors = 0;
    int checks = 0;

    bit       bitq[$];
    bit [7:0] exp_q[$];
    bit       flush_pending = 1'b0;
    bit       hold_v = 1'b0;
    bit [7:0] hold_b = '0;

    always #5 clk = ~clk;

    jpeg_entropy_bit_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_len     (in_len),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
`ifdef JPEG_PACK_PARITY_EN
        .flush_done (flush_done),
        .out_par    (out_par)
`else
        .flush_done (flush_done)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // JPEG stream model: bytes from the bit queue, 0x00 after each 0xFF.
    task automatic push_byte(input bit [7:0] b);
        exp_q.push_back(b);
        if (b == 8'hFF) exp_q.push_back(8'h00);
    endtask

    task automatic pack_bytes();
        bit [7:0] b;
        while (bitq.size() >= 8) begin
            for (int i = 0; i < 8; i++) b = {b[6:0], bitq.pop_front()};
            push_byte(b);
        end
    endtask

    task automatic model_accept(input logic [15:0] code, input logic [4:0] len);
        int le;
        le = (len > 16) ? 16 : int'(len);
        for (int i = le - 1; i >= 0; i--) bitq.push_back(code[i]);
        pack_bytes();
    endtask

    task automatic model_flush();
        if (bitq.size() > 0) begin
            while (bitq.size() < 8) bitq.push_back(1'b1);
            pack_bytes();
        end
    endtask

    // One cycle: account for the handshakes the coming posedge will perform, then step to the next negedge.
    task automatic tick();
        if (rst_n) begin
            if (hold_v) begin
                check("hold_valid", out_valid, 1);
                check("hold_byte", out_byte, hold_b);
            end
            if (out_valid && out_ready) begin
                check("byte_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("stream_byte", out_byte, exp_q.pop_front());
            end
            hold_v = out_valid && !out_ready;
            hold_b = out_byte;
            if (flush_done) begin
                check("done_while_flushing", flush_pending, 1);
                check("done_drained", exp_q.size(), 0);
                flush_pending = 1'b0;
            end
            if (in_valid && in_ready) model_accept(in_code, in_len);
            if (flush) begin
                model_flush();
                flush_pending = 1'b1;
            end
        end else begin
            bitq.delete();
            exp_q.delete();
            hold_v = 1'b0;
            flush_pending = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] code, input logic [4:0] len);
        in_valid = 1'b1;
        in_code  = code;
        in_len   = len;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        bit [7:0] t4[4];
        int budget;
        t4[0] = 8'hA5; t4[1] = 8'hC3; t4[2] = 8'h12; t4[3] = 8'h34;
        @(negedge clk);
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_byte", out_byte, 8'h00);
        check("rst_flush_done", flush_done, 0);
`ifdef JPEG_PACK_PARITY_EN
        check("rst_out_par", out_par, 1);
`endif
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", in_ready, 1);

        // 1: two codes fill exactly one byte
        out_ready = 1'b1;
        in_valid = 1'b1; in_code = 16'h0005; in_len = 5'd3;
        tick();
        in_code = 16'h001E; in_len = 5'd5;
        tick();
        in_valid = 1'b0;
        check("t1_valid", out_valid, 1);
        check("t1_byte", out_byte, 8'hBE);
        tick();
        check("t1_empty", out_valid, 0);

        // 2: 0xFF is followed by a stuffed 0x00
        send(16'h00FF, 5'd8);
        check("t2_ff", out_byte, 8'hFF);
        tick();
        check("t2_stuff_valid", out_valid, 1);
        check("t2_stuff_byte", out_byte, 8'h00);
        tick();
        check("t2_idle", out_valid, 0);

        // 3: flush pads 010 with ones; flush_done one cycle after the handshake
        send(16'h0002, 5'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3_pad_valid", out_valid, 1);
        check("t3_pad_byte", out_byte, 8'h5F);
        tick();
        check("t3_done_early", flush_done, 0);
        tick();
        check("t3_done", flush_done, 1);
        tick();
        check("t3_done_pulse", flush_done, 0);

        // 4: back-pressure fills the accumulator; release drains in order
        out_ready = 1'b0;
        send(16'hA5C3, 5'd16);
        send(16'h1234, 5'd16);
        check("t4_full", in_ready, 0);
        send(16'h5555, 5'd16);
        check("t4_still_full", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t4_order", out_byte, t4[i]);
            tick();
        end
        check("t4_ready", in_ready, 1);
        check("t4_drained", out_valid, 0);

        // 5: reset mid-operation discards 20 buffered bits
        out_ready = 1'b0;
        send(16'h1357, 5'd16);
        send(16'h0009, 5'd4);
        rst_n = 1'b0;
        tick();
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_ready", in_ready, 0);
        rst_n = 1'b1;
        tick();
        check("t5_ready", in_ready, 1);
        check("t5_no_stale", out_valid, 0);
        out_ready = 1'b1;
        send(16'h00C4, 5'd8);
        check("t5_fresh", out_byte, 8'hC4);
        tick();

`ifdef JPEG_PACK_PARITY_EN
        // 6: parity follows the registered byte
        send(16'h0000, 5'd8);
        check("t6_par00", out_par, 1);
        tick();
        send(16'h0001, 5'd8);
        check("t6_par01", out_par, 0);
        tick();
        send(16'h00BE, 5'd8);
        check("t6_parBE", out_par, 1);
        tick();
`endif

        // Randomized traffic with occasional flushes
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_code   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            in_len    = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = !flush_pending && !flush_done && !out_valid && ($urandom_range(0, 24) == 0);
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while ((flush_pending || out_valid || flush_done) && budget < 200) begin
            tick();
            budget++;
        end
        check("settle_timeout", budget < 200, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        budget = 0;
        while (flush_pending && budget < 200) begin
            tick();
            budget++;
        end
        check("final_flush_done", flush_pending, 0);
        check("final_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
